// File: rtl/cdb_arbiter_if.sv
// FU result handshake and registered CDB broadcast bundle for cdb_arbiter.
// The master side is the FUs and the broadcast consumers. The slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]        fu_valid_i;
    logic [NUM_FU-1:0]        fu_ready_o;
    logic [NUM_FU*TAG_W-1:0]  fu_tag_i;
    logic [NUM_FU*DATA_W-1:0] fu_data_i;
    logic                     cdb_en_o;
    logic [TAG_W-1:0]         cdb_reg_addr_o;
    logic [DATA_W-1:0]        cdb_data_o;
    logic [FU_W-1:0]          cdb_fu_o;

    modport master (
        output fu_valid_i, fu_tag_i, fu_data_i,
        input  fu_ready_o, cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_fu_o
    );

    modport slave (
        input  fu_valid_i, fu_tag_i, fu_data_i,
        output fu_ready_o, cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_fu_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: buffers FU results in per-FU FIFOs and broadcasts one result per cycle from a registered output.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index priority. The default build uses round-robin arbitration.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           fifo_mem [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
    logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
    logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
    logic [CNT_W-1:0] count_q  [NUM_FU];
    logic [CNT_W-1:0] count_d  [NUM_FU];

    logic              cdb_en_q,   cdb_en_d;
    logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [FU_W-1:0]   cdb_fu_q,   cdb_fu_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
    logic [FU_W-1:0]   rr_ptr_q,   rr_ptr_d;
`endif

    logic [NUM_FU-1:0] fu_ready;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              grant_vld;
    logic [FU_W-1:0]   grant_idx;
    entry_t            grant_entry;

    // Ready is derived from the registered count alone, so a full FIFO stays not-ready even while it is being popped.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = count_q[i] < CNT_W'(FIFO_DEPTH);
            req[i]      = count_q[i] != '0;
        end
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_vld = 1'b1;
                grant_idx = FU_W'(i);
            end
        end
    end
`else
    logic [FU_W-1:0] scan_idx;

    // Scan from the farthest candidate to the nearest one, so the first requester at or after rr_ptr wins.
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            scan_idx = FU_W'((int'(rr_ptr_q) + k) % NUM_FU);
            if (req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end
`endif

    assign grant_entry = fifo_mem[grant_idx][rd_ptr_q[grant_idx]];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            push[i]     = bus.fu_valid_i[i] && fu_ready[i] && !flush_i;
            pop[i]      = grant_vld && (grant_idx == FU_W'(i)) && !flush_i;
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
            if (flush_i) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
        end

        // Tag and data hold their last value when idle. Only cdb_en is qualified.
        cdb_en_d   = 1'b0;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        cdb_fu_d   = cdb_fu_q;
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (grant_vld && !flush_i) begin
            // A tag-0 result maps to x0: it is popped but never broadcast.
            cdb_en_d   = grant_entry.tag != '0;
            cdb_tag_d  = grant_entry.tag;
            cdb_data_d = grant_entry.data;
            cdb_fu_d   = grant_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_d   = FU_W'((int'(grant_idx) + 1) % NUM_FU);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            cdb_en_q   <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
            cdb_fu_q   <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            cdb_en_q   <= cdb_en_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
            cdb_fu_q   <= cdb_fu_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // NOTE: the result storage has no reset. Only entries counted by count_q are ever read, so clearing pointers and counts is enough.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= {bus.fu_tag_i[i*TAG_W +: TAG_W], bus.fu_data_i[i*DATA_W +: DATA_W]};
            end
        end
    end

    assign bus.fu_ready_o     = fu_ready;
    assign bus.cdb_en_o       = cdb_en_q;
    assign bus.cdb_reg_addr_o = cdb_tag_q;
    assign bus.cdb_data_o     = cdb_data_q;
    assign bus.cdb_fu_o       = cdb_fu_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: cycle-exact vector table plus a per-FU broadcast scoreboard.
// The expected arbitration order follows the CDB_ARB_FIXED_PRIO_EN setting of the build.
module tb_cdb_arbiter;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    logic flush_i = 1'b0;

    cdb_arbiter_if #(.NUM_FU(4), .TAG_W(6), .DATA_W(32)) bus ();

    cdb_arbiter #(.NUM_FU(4), .TAG_W(6), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0][5:0] tags;
        logic [3:0]      rdy;
        logic            en;
        logic [1:0]      fu;
    } vec_t;

    typedef struct {
        logic [1:0]  fu;
        logic [5:0]  tag;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int fu, input logic [5:0] tag);
        return 32'hC0DE_0000 | (32'(fu) << 8) | {26'd0, tag};
    endfunction

    task automatic add(input logic [3:0] v, input int t0, input int t1, input int t2, input int t3,
                       input logic [3:0] r, input logic e, input int f);
        vec_t x;
        x.valid = v;
        x.tags  = {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
        x.rdy   = r;
        x.en    = e;
        x.fu    = 2'(f);
        vecs.push_back(x);
    endtask

    // Match an observed broadcast against the oldest outstanding result of the same FU.
    task automatic monitor(input string name);
        int idx;
        idx = -1;
        if (bus.cdb_en_o !== 1'b1) return;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].fu == bus.cdb_fu_o) idx = i;
        end
        if (idx < 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s unexpected broadcast: got tag %0d from fu %0d, want none", name, bus.cdb_reg_addr_o, bus.cdb_fu_o);
        end else begin
            check({name, " bcast tag"}, 64'(bus.cdb_reg_addr_o), 64'(sb[idx].tag));
            check({name, " bcast data"}, 64'(bus.cdb_data_o), 64'(sb[idx].data));
            sb.delete(idx);
        end
    endtask

    // Starts at a negedge: checks ready, drives the inputs for one rising edge, then checks the outputs at the next negedge.
    task automatic step(input logic [3:0] valid, input logic [3:0][5:0] tags, input logic [3:0][31:0] datas,
                        input logic flush, input logic [3:0] exp_rdy, input logic exp_en, input logic [1:0] exp_fu,
                        input string name);
        check({name, " ready"}, 64'(bus.fu_ready_o), 64'(exp_rdy));
        bus.fu_valid_i = valid;
        bus.fu_tag_i   = tags;
        bus.fu_data_i  = datas;
        flush_i        = flush;
        if (flush) sb.delete();
        else begin
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && exp_rdy[i] && tags[i] != 6'd0) sb.push_back('{fu: 2'(i), tag: tags[i], data: datas[i]});
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        bus.fu_valid_i = '0;
        flush_i        = 1'b0;
        check({name, " en"}, 64'(bus.cdb_en_o), 64'(exp_en));
        if (exp_en) check({name, " fu"}, 64'(bus.cdb_fu_o), 64'(exp_fu));
        monitor(name);
    endtask

    task automatic idle(input logic [3:0] exp_rdy, input logic exp_en, input logic [1:0] exp_fu, input string name);
        step(4'b0000, '0, '0, 1'b0, exp_rdy, exp_en, exp_fu, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][5:0]  tags;
        logic [3:0][31:0] datas;

        bus.fu_valid_i = '0;
        bus.fu_tag_i   = '0;
        bus.fu_data_i  = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        check("reset en", 64'(bus.cdb_en_o), 64'd0);
        check("reset tag", 64'(bus.cdb_reg_addr_o), 64'd0);
        check("reset data", 64'(bus.cdb_data_o), 64'd0);
        check("reset fu", 64'(bus.cdb_fu_o), 64'd0);
        check("reset ready", 64'(bus.fu_ready_o), 64'hF);

        // Contention: two overlapping waves, each drained in FU order starting from FU0.
        add(4'b1111, 1, 2, 3, 4, 4'b1111, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 0);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 2);
        add(4'b1111, 5, 6, 7, 8, 4'b1111, 1, 3);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 0);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 2);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 3);
        // Tag 0 followed by tag 9 on FU1: the tag-0 slot is a silent cycle.
        add(4'b0010, 0, 0, 0, 0, 4'b1111, 0, 0);
        add(4'b0010, 0, 9, 0, 0, 4'b1111, 0, 0);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 1, 1);
        add(4'b0000, 0, 0, 0, 0, 4'b1111, 0, 0);
`ifdef CDB_ARB_FIXED_PRIO_EN
        // Backpressure: FU0 saturates, FU2 fills after two pushes and its third result waits for the first pop.
        add(4'b0111, 10, 20, 30, 0, 4'b1111, 0, 0);
        add(4'b0111, 11, 21, 31, 0, 4'b1111, 1, 0);
        add(4'b0111, 12, 22, 32, 0, 4'b1001, 1, 0);
        add(4'b0111, 13, 22, 32, 0, 4'b1001, 1, 0);
        add(4'b0110,  0, 22, 32, 0, 4'b1001, 1, 0);
        add(4'b0110,  0, 22, 32, 0, 4'b1001, 1, 1);
        add(4'b0110,  0, 22, 32, 0, 4'b1011, 1, 1);
        add(4'b0100,  0,  0, 32, 0, 4'b1011, 1, 1);
        add(4'b0100,  0,  0, 32, 0, 4'b1011, 1, 2);
        add(4'b0100,  0,  0, 32, 0, 4'b1111, 1, 2);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 1, 2);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 0, 0);
`else
        // Backpressure under round-robin: FU0..FU2 push continuously and hold whenever they are not ready.
        add(4'b0001, 10,  0,  0, 0, 4'b1111, 0, 0);
        add(4'b0111, 11, 20, 30, 0, 4'b1111, 1, 0);
        add(4'b0111, 12, 21, 31, 0, 4'b1111, 1, 1);
        add(4'b0111, 13, 22, 32, 0, 4'b1010, 1, 2);
        add(4'b0111, 13, 23, 32, 0, 4'b1100, 1, 0);
        add(4'b0011, 13, 23,  0, 0, 4'b1001, 1, 1);
        add(4'b0010,  0, 23,  0, 0, 4'b1010, 1, 2);
        add(4'b0000,  0,  0,  0, 0, 4'b1100, 1, 0);
        add(4'b0000,  0,  0,  0, 0, 4'b1101, 1, 1);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 1, 2);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 1, 0);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 1, 1);
        add(4'b0000,  0,  0,  0, 0, 4'b1111, 0, 0);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            for (int i = 0; i < 4; i++) datas[i] = data_of(i, vecs[n].tags[i]);
            step(vecs[n].valid, vecs[n].tags, datas, 1'b0, vecs[n].rdy, vecs[n].en, vecs[n].fu, $sformatf("vec%0d", n));
        end

        // Single result: two-cycle latency, then the broadcast drops.
        tags  = {6'd0, 6'd0, 6'd0, 6'd5};
        datas = {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF};
        step(4'b0001, tags, datas, 1'b0, 4'b1111, 1'b0, 2'd0, "single push");
        idle(4'b1111, 1'b1, 2'd0, "single bcast");
        idle(4'b1111, 1'b0, 2'd0, "single done");

        // Flush: three buffered results, plus an FU3 push in the flush cycle that must be dropped.
        tags = {6'd0, 6'd42, 6'd41, 6'd40};
        for (int i = 0; i < 4; i++) datas[i] = data_of(i, tags[i]);
        step(4'b0111, tags, datas, 1'b0, 4'b1111, 1'b0, 2'd0, "flush fill");
        tags  = {6'd43, 6'd0, 6'd0, 6'd0};
        datas = {data_of(3, 6'd43), 32'd0, 32'd0, 32'd0};
        step(4'b1000, tags, datas, 1'b1, 4'b1111, 1'b0, 2'd0, "flush pulse");
        for (int n = 0; n < 4; n++) idle(4'b1111, 1'b0, 2'd0, $sformatf("post flush%0d", n));

        // Async reset mid-stream: FU1 still holds a result when reset arrives between edges.
        tags  = {6'd0, 6'd0, 6'd51, 6'd0};
        datas = {32'd0, 32'd0, data_of(1, 6'd51), 32'd0};
        step(4'b0010, tags, datas, 1'b0, 4'b1111, 1'b0, 2'd0, "pre reset a");
        tags  = {6'd0, 6'd0, 6'd52, 6'd0};
        datas = {32'd0, 32'd0, data_of(1, 6'd52), 32'd0};
        step(4'b0010, tags, datas, 1'b0, 4'b1111, 1'b1, 2'd1, "pre reset b");
        reset_i = 1'b1;
        #1;
        sb.delete();
        check("async reset en", 64'(bus.cdb_en_o), 64'd0);
        check("async reset ready", 64'(bus.fu_ready_o), 64'hF);
        check("async reset tag", 64'(bus.cdb_reg_addr_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        tags  = {6'd60, 6'd0, 6'd0, 6'd0};
        datas = {data_of(3, 6'd60), 32'd0, 32'd0, 32'd0};
        step(4'b1000, tags, datas, 1'b0, 4'b1111, 1'b0, 2'd0, "post reset push");
        idle(4'b1111, 1'b1, 2'd3, "post reset bcast");
        idle(4'b1111, 1'b0, 2'd0, "post reset idle");

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
